// File: rtl/sort_engine_if.sv
// Command/status bundle for sort_engine: toggle-encoded commands, push/pop data and status flags.
// The master side issues commands; the slave side is the engine.
interface sort_engine_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          enable;
  logic          clear;
  logic          push;
  logic          pop;
  logic          sort;
  logic          descend;
  logic          signed_cmp;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] tx_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          idle;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output enable, clear, push, pop, sort, descend, signed_cmp, rx_data,
    input  tx_data, count, full, empty, idle, busy, done, err
  );

  modport slave (
    input  enable, clear, push, pop, sort, descend, signed_cmp, rx_data,
    output tx_data, count, full, empty, idle, busy, done, err
  );
endinterface

// File: rtl/sort_engine.sv
// Stack-style element store with push/pop and an in-place stable insertion sort.
// Commands are toggle-encoded and accepted only while idle.
//
// state | meaning
// IDLE  | accepting clear/push/pop/sort requests
// INIT  | i <= 1, skip straight to DONE when fewer than two elements
// LOAD  | key <= A[i], j <= i
// SCAN  | shift A[j-1] up while key precedes it, else insert key
// DONE  | one-cycle done pulse, back to IDLE
module sort_engine #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  sort_engine_if.slave  bus
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  typedef enum logic [2:0] {IDLE, INIT, LOAD, SCAN, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW-1:0] i_idx, j_idx, j_prev, top_idx;
  logic [DW-1:0] key, prev, tx_q;
  logic          err_q, desc_q, sgn_q;
  logic          clear_q, push_q, pop_q, sort_q;
  logic          clear_req, push_req, pop_req, sort_req, any_req;
  logic          do_clear, do_push, do_pop, do_sort, drop, shift, insert;
  logic          is_full, is_empty, lt, gt, key_prec;

  assign clear_req = bus.enable & (bus.clear ^ clear_q);
  assign push_req  = bus.enable & (bus.push  ^ push_q);
  assign pop_req   = bus.enable & (bus.pop   ^ pop_q);
  assign sort_req  = bus.enable & (bus.sort  ^ sort_q);
  assign any_req   = clear_req | push_req | pop_req | sort_req;

  assign is_full  = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);
  assign top_idx  = cnt[AW-1:0] - IDX_ONE;
  assign j_prev   = j_idx - IDX_ONE;
  assign prev     = mem[j_prev];

  // Strict compares keep equal keys in input order.
  assign lt       = sgn_q ? ($signed(key) < $signed(prev)) : (key < prev);
  assign gt       = sgn_q ? ($signed(key) > $signed(prev)) : (key > prev);
  assign key_prec = desc_q ? gt : lt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (bus.enable) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    do_clear = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_sort  = 1'b0;
    drop     = 1'b0;
    shift    = 1'b0;
    insert   = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          do_clear = 1'b1;
          drop     = push_req | pop_req | sort_req;
        end else if (push_req) begin
          do_push = 1'b1;
          drop    = pop_req | sort_req;
        end else if (pop_req) begin
          do_pop = 1'b1;
          drop   = sort_req;
        end else if (sort_req) begin
          do_sort  = 1'b1;
          state_nx = INIT;
        end
      end
      INIT: state_nx = (cnt <= CNT_ONE) ? DONE : LOAD;
      LOAD: state_nx = SCAN;
      SCAN: begin
        if ((j_idx != '0) && key_prec) begin
          shift = 1'b1;
        end else begin
          insert   = 1'b1;
          state_nx = (({1'b0, i_idx} + CNT_ONE) == cnt) ? DONE : LOAD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state != IDLE) drop = any_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tx_q    <= '0;
      err_q   <= 1'b0;
      desc_q  <= 1'b0;
      sgn_q   <= 1'b0;
      i_idx   <= '0;
      j_idx   <= '0;
      key     <= '0;
      clear_q <= bus.clear;
      push_q  <= bus.push;
      pop_q   <= bus.pop;
      sort_q  <= bus.sort;
    end else if (bus.enable) begin
      clear_q <= bus.clear;
      push_q  <= bus.push;
      pop_q   <= bus.pop;
      sort_q  <= bus.sort;
      if (do_clear) begin
        cnt   <= '0;
        err_q <= 1'b0;
      end
      if (do_push) begin
        if (is_full) err_q <= 1'b1;
        else         cnt   <= cnt + CNT_ONE;
      end
      if (do_pop) begin
        if (is_empty) begin
          err_q <= 1'b1;
        end else begin
          tx_q <= mem[top_idx];
          cnt  <= cnt - CNT_ONE;
        end
      end
      if (do_sort) begin
        desc_q <= bus.descend;
        sgn_q  <= bus.signed_cmp;
      end
      if (state == INIT) i_idx <= IDX_ONE;
      if (state == LOAD) begin
        key   <= mem[i_idx];
        j_idx <= i_idx;
      end
      if (shift)  j_idx <= j_prev;
      if (insert) i_idx <= i_idx + IDX_ONE;
      // A dropped request flags an error even when a clear is accepted alongside it.
      if (drop) err_q <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.enable) begin
      if (do_push && !is_full) mem[cnt[AW-1:0]] <= bus.rx_data;
      if (shift)               mem[j_idx] <= prev;
      if (insert)              mem[j_idx] <= key;
    end
  end

  assign bus.tx_data = tx_q;
  assign bus.count   = cnt;
  assign bus.full    = is_full;
  assign bus.empty   = is_empty;
  assign bus.idle    = (state == IDLE);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: a reference model of the store feeds a queue of
// expected pop values and sort timings that are compared against the engine's outputs.
module tb_sort_engine;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_tx = 8'h00;

  sort_engine_if #(.DW(8), .AW(4)) bus ();
  sort_engine #(.DW(8), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic bit prec(input logic [7:0] a, input logic [7:0] b,
                              input logic d, input logic s);
    int ia, ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    return d ? (ia > ib) : (ia < ib);
  endfunction

  // Busy cycles from inversion counts of the unsorted contents.
  function automatic int model_busy(input logic d, input logic s);
    int tot, inv;
    if (model.size() <= 1) return 2;
    tot = 2;
    for (int i = 1; i < model.size(); i++) begin
      inv = 0;
      for (int j = 0; j < i; j++) if (prec(model[i], model[j], d, s)) inv++;
      tot += 2 + inv;
    end
    return tot;
  endfunction

  // Stable bubble sort of the reference contents.
  task automatic model_sort(input logic d, input logic s);
    logic [7:0] t;
    for (int p = 0; p < model.size(); p++)
      for (int k = 0; k + 1 < model.size(); k++)
        if (prec(model[k+1], model[k], d, s)) begin
          t = model[k]; model[k] = model[k+1]; model[k+1] = t;
        end
  endtask

  task automatic tog_push(input logic [7:0] v);
    @(negedge clk);
    bus.rx_data = v;
    bus.push = ~bus.push;
    @(posedge clk); #1;
    if (model.size() < 16) model.push_back(v);
  endtask

  task automatic tog_pop();
    @(negedge clk);
    bus.pop = ~bus.pop;
    @(posedge clk); #1;
    if (model.size() > 0) last_tx = model.pop_back();
    exp_q.push_back(last_tx);
  endtask

  task automatic tog_clear();
    @(negedge clk);
    bus.clear = ~bus.clear;
    @(posedge clk); #1;
    model.delete();
  endtask

  task automatic run_sort(input logic d, input logic s, input logic inject_push,
                          output int busy_n, output int done_n, output int exp_busy);
    exp_busy = model_busy(d, s);
    @(negedge clk);
    bus.descend = d;
    bus.signed_cmp = s;
    bus.sort = ~bus.sort;
    @(posedge clk); #1;
    busy_n = 0;
    done_n = 0;
    while (bus.busy && busy_n < 300) begin
      busy_n++;
      if (bus.done) done_n++;
      @(negedge clk);
      bus.descend = ~d;
      bus.signed_cmp = ~s;
      if (inject_push && busy_n == 1) begin
        bus.rx_data = 8'hEE;
        bus.push = ~bus.push;
      end
      @(posedge clk); #1;
    end
    model_sort(d, s);
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.sort = 1'b0;
    bus.descend = 1'b0; bus.signed_cmp = 1'b0; bus.rx_data = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.count, bus.tx_data, bus.empty, bus.full, bus.idle, bus.busy, bus.done, bus.err}
        !== {5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset: count=%0d tx=%h empty=%b full=%b idle=%b busy=%b done=%b err=%b",
               bus.count, bus.tx_data, bus.empty, bus.full, bus.idle, bus.busy, bus.done, bus.err);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enable();
    @(negedge clk);
    bus.enable = 1'b0;
    bus.rx_data = 8'h55;
    bus.push = ~bus.push;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.count !== 5'd0) begin
      $display("FAIL enable_hold: count=%0d expected 0", bus.count); errors++;
    end
    @(negedge clk);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    model.push_back(8'h55);
    checks++;
    if (bus.count !== 5'd1) begin
      $display("FAIL enable_resume: count=%0d expected 1", bus.count); errors++;
    end
    tog_pop();
    checks++;
    if (bus.tx_data !== exp_q.pop_front()) begin
      $display("FAIL enable_pop: tx=%h expected 55", bus.tx_data); errors++;
    end
  endtask

  task automatic sort_case(input string nm, input logic d, input logic s);
    int b, dn, eb, n;
    n = model.size();
    run_sort(d, s, 1'b0, b, dn, eb);
    checks++;
    if (b !== eb || dn !== 1) begin
      $display("FAIL %s_timing: busy=%0d done=%0d expected busy=%0d done=1", nm, b, dn, eb);
      errors++;
    end
    repeat (n) begin
      tog_pop();
      checks++;
      if (bus.tx_data !== exp_q[0]) begin
        $display("FAIL %s_pop: tx=%h expected %h", nm, bus.tx_data, exp_q[0]); errors++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_basic();
    tog_push(8'd3); tog_push(8'd1); tog_push(8'd2);
    checks++;
    if (model_busy(1'b0, 1'b0) != 8) begin
      $display("FAIL basic_model: busy=%0d expected 8", model_busy(1'b0, 1'b0)); errors++;
    end
    sort_case("basic", 1'b0, 1'b0);
  endtask

  task automatic test_order();
    tog_push(8'd4); tog_push(8'd3); tog_push(8'd2); tog_push(8'd1);
    sort_case("asc", 1'b0, 1'b0);
    tog_push(8'd1); tog_push(8'd2); tog_push(8'd3); tog_push(8'd4);
    sort_case("desc", 1'b1, 1'b0);
    tog_push(8'h80); tog_push(8'h7F);
    sort_case("signed", 1'b0, 1'b1);
    tog_push(8'h80); tog_push(8'h7F);
    sort_case("unsigned", 1'b0, 1'b0);
    tog_push(8'h42);
    sort_case("single", 1'b0, 1'b0);
  endtask

  task automatic test_full();
    repeat (16) tog_push(8'($urandom_range(0, 255)));
    tog_push(8'h10); tog_push(8'h10);
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.err !== 1'b1) begin
      $display("FAIL full_random: full=%b count=%0d err=%b expected 1/16/1",
               bus.full, bus.count, bus.err); errors++;
    end
    tog_clear();
    repeat (16) tog_push(8'($urandom_range(0, 255)));
    sort_case("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (16) tog_push(8'($urandom_range(0, 255)));
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.err !== 1'b0) begin
      $display("FAIL full: full=%b count=%0d err=%b expected 1/16/0", bus.full, bus.count, bus.err);
      errors++;
    end
    tog_push(8'hAA);
    checks++;
    if (bus.count !== 5'd16 || bus.err !== 1'b1) begin
      $display("FAIL overflow: count=%0d err=%b expected 16/1", bus.count, bus.err); errors++;
    end
    tog_clear();
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.err !== 1'b0) begin
      $display("FAIL clear: count=%0d empty=%b err=%b expected 0/1/0", bus.count, bus.empty, bus.err);
      errors++;
    end
    tog_pop();
    checks++;
    if (bus.tx_data !== exp_q[0] || bus.err !== 1'b1 || bus.count !== 5'd0) begin
      $display("FAIL underflow: tx=%h err=%b count=%0d expected %h/1/0",
               bus.tx_data, bus.err, bus.count, exp_q[0]); errors++;
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_conflict();
    int b, dn, eb;
    tog_clear();
    @(negedge clk);
    bus.rx_data = 8'h21;
    bus.push = ~bus.push;
    bus.pop = ~bus.pop;
    @(posedge clk); #1;
    model.push_back(8'h21);
    checks++;
    if (bus.count !== 5'd1 || bus.err !== 1'b1 || bus.tx_data !== last_tx) begin
      $display("FAIL push_pop_same: count=%0d err=%b tx=%h expected 1/1/%h",
               bus.count, bus.err, bus.tx_data, last_tx); errors++;
    end
    tog_clear();
    tog_push(8'd5); tog_push(8'd9); tog_push(8'd2);
    run_sort(1'b1, 1'b0, 1'b1, b, dn, eb);
    checks++;
    if (b !== eb || dn !== 1 || bus.err !== 1'b1 || bus.count !== 5'd3) begin
      $display("FAIL push_during_sort: busy=%0d done=%0d err=%b count=%0d expected %0d/1/1/3",
               b, dn, bus.err, bus.count, eb); errors++;
    end
    repeat (3) begin
      tog_pop();
      checks++;
      if (bus.tx_data !== exp_q[0]) begin
        $display("FAIL conflict_pop: tx=%h expected %h", bus.tx_data, exp_q[0]); errors++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_rst_mid();
    int done_seen;
    tog_clear();
    tog_push(8'd1); tog_push(8'd3); tog_push(8'd5); tog_push(8'd7);
    @(negedge clk);
    bus.sort = ~bus.sort;
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    if (bus.done) done_seen++;
    checks++;
    if ({bus.idle, bus.busy, bus.count, bus.tx_data} !== {1'b1, 1'b0, 5'd0, 8'h00}) begin
      $display("FAIL rst_mid: idle=%b busy=%b count=%0d tx=%h expected 1/0/0/00",
               bus.idle, bus.busy, bus.count, bus.tx_data); errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    last_tx = 8'h00;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    checks++;
    if (done_seen !== 0 || bus.idle !== 1'b1 || bus.count !== 5'd0 || bus.err !== 1'b0) begin
      $display("FAIL rst_after: done_pulses=%0d idle=%b count=%0d err=%b expected 0/1/0/0",
               done_seen, bus.idle, bus.count, bus.err); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_basic();
    test_order();
    test_full();
    test_conflict();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
